// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-port arbiter/sequencer that is the only driver of the
// 8-word x 8-bit memory array. Grants one port, drives the array for one
// ACCESS cycle, then acks the winner in RESP (one transaction per 3 clocks).
// Optional build macro: ARB_FIXED_PRIO_EN -- port 0 always wins a tie and
// no round-robin history is kept. Default build is round-robin.
module mem_port_arbiter #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              req0,
  input  logic              rw0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  input  logic              req1,
  input  logic              rw1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              gnt_id,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_add,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmd_t;

  cmd_t [1:0] cmd;
  logic [1:0] req;
  logic       win;

  assign cmd[0] = {rw0, addr0, wdata0};
  assign cmd[1] = {rw1, addr1, wdata1};
  assign req    = {req1, req0};

  state_e            state_q, state_d;
  logic [1:0]        ack_q, ack_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              busy_q, busy_d;
  logic              gnt_q, gnt_d;
  logic              mem_rw_q, mem_rw_d;
  logic [ADDR_W-1:0] mem_add_q, mem_add_d;
  logic [DATA_W-1:0] mem_din_q, mem_din_d;
`ifndef ARB_FIXED_PRIO_EN
  logic              rr_last_q, rr_last_d;
`endif

  // Winner of the IDLE-cycle arbitration (only meaningful when some req is high).
  always_comb begin
`ifdef ARB_FIXED_PRIO_EN
    win = ~req[0];
`else
    win = (&req) ? ~rr_last_q : req[1];
`endif
  end

  // Next-state and next-output logic; mem_rw is only ever high for the
  // ACCESS cycle because the array always decodes some row.
  always_comb begin
    state_d   = state_q;
    ack_d     = '0;
    rdata_d   = rdata_q;
    busy_d    = busy_q;
    gnt_d     = gnt_q;
    mem_rw_d  = 1'b0;
    mem_add_d = mem_add_q;
    mem_din_d = mem_din_q;
`ifndef ARB_FIXED_PRIO_EN
    rr_last_d = rr_last_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d   = S_ACCESS;
          busy_d    = 1'b1;
          gnt_d     = win;
          mem_rw_d  = cmd[win].rw;
          mem_add_d = cmd[win].addr;
          mem_din_d = cmd[win].data;
        end
      end
      S_ACCESS: begin
        state_d = S_RESP;
        if (!mem_rw_q) rdata_d = mem_dout;
        ack_d[gnt_q] = 1'b1;
      end
      S_RESP: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
`ifndef ARB_FIXED_PRIO_EN
        rr_last_d = gnt_q;
`endif
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; clear drops mem_rw at once so an
  // in-flight write never reaches the array.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q   <= S_IDLE;
      ack_q     <= '0;
      rdata_q   <= '0;
      busy_q    <= 1'b0;
      gnt_q     <= 1'b0;
      mem_rw_q  <= 1'b0;
      mem_add_q <= '0;
      mem_din_q <= '0;
`ifndef ARB_FIXED_PRIO_EN
      rr_last_q <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      busy_q    <= busy_d;
      gnt_q     <= gnt_d;
      mem_rw_q  <= mem_rw_d;
      mem_add_q <= mem_add_d;
      mem_din_q <= mem_din_d;
`ifndef ARB_FIXED_PRIO_EN
      rr_last_q <= rr_last_d;
`endif
    end
  end

  assign ack0    = ack_q[0];
  assign ack1    = ack_q[1];
  assign rdata   = rdata_q;
  assign busy    = busy_q;
  assign gnt_id  = gnt_q;
  assign mem_rw  = mem_rw_q;
  assign mem_add = mem_add_q;
  assign mem_din = mem_din_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, a hand-written abort
// sequence, then random traffic against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int AW = 3;
  localparam int DW = 8;
`ifdef ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          clear = 1'b0;
  logic          req0 = 1'b0, rw0 = 1'b0, req1 = 1'b0, rw1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          ack0, ack1, busy, gnt_id, mem_rw;
  logic [DW-1:0] rdata, mem_din, mem_dout;
  logic [AW-1:0] mem_add;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .clear(clear),
    .req0(req0), .rw0(rw0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
    .req1(req1), .rw1(rw1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
    .rdata(rdata), .busy(busy), .gnt_id(gnt_id),
    .mem_rw(mem_rw), .mem_add(mem_add), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // The memory array: write at the clock edge, combinational read.
  logic [DW-1:0] arr [8] = '{default: 8'h00};
  always @(posedge clk) if (mem_rw) arr[mem_add] <= mem_din;
  assign mem_dout = arr[mem_add];

  typedef struct { logic rw; logic [AW-1:0] a; logic [DW-1:0] d; } cmd_t;
  typedef struct { logic r0; cmd_t c0; logic r1; cmd_t c1; logic eg; logic [DW-1:0] erd; } vec_t;

  int total = 0;
  int bad = 0;

  // Transaction-level model state.
  logic [DW-1:0] mem_m [8];
  bit            rr_m;
  logic [DW-1:0] rd_m;

  vec_t tbl [20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  function automatic cmd_t C(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd_t c;
    c.rw = rw; c.a = a; c.d = d;
    return c;
  endfunction

  function automatic vec_t V(input bit r0, input cmd_t c0, input bit r1, input cmd_t c1,
                             input bit eg, input logic [DW-1:0] erd);
    vec_t v;
    v.r0 = r0; v.c0 = c0; v.r1 = r1; v.c1 = c1; v.eg = eg; v.erd = erd;
    return v;
  endfunction

  function automatic cmd_t rnd_cmd();
    return C(1'($urandom_range(1)), 3'($urandom_range(7)), 8'($urandom_range(255)));
  endfunction

  // Model arbitration: a lone requester wins; on a tie the port that was
  // not served last wins (or port 0 under fixed priority).
  function automatic bit pick(input bit r0, input bit r1);
    if (r0 && r1) return FIXED ? 1'b0 : !rr_m;
    return r1;
  endfunction

  // One transaction starting from an IDLE negedge, checked cycle by cycle.
  task automatic txn(input vec_t v, input string nm);
    cmd_t c;
    c = v.eg ? v.c1 : v.c0;
    req0 = v.r0; rw0 = v.c0.rw; addr0 = v.c0.a; wdata0 = v.c0.d;
    req1 = v.r1; rw1 = v.c1.rw; addr1 = v.c1.a; wdata1 = v.c1.d;
    @(negedge clk);
    chk({nm, ".acc.busy"},    busy,        1);
    chk({nm, ".acc.mem_rw"},  mem_rw,      c.rw);
    chk({nm, ".acc.mem_add"}, mem_add,     c.a);
    chk({nm, ".acc.mem_din"}, mem_din,     c.d);
    chk({nm, ".acc.gnt_id"},  gnt_id,      v.eg);
    chk({nm, ".acc.ack"},     {ack1, ack0}, 0);
    @(negedge clk);
    chk({nm, ".resp.ack"},    {ack1, ack0}, v.eg ? 2 : 1);
    chk({nm, ".resp.rdata"},  rdata,       v.erd);
    chk({nm, ".resp.mem_rw"}, mem_rw,      0);
    chk({nm, ".resp.busy"},   busy,        1);
    if (v.eg) req1 = 1'b0; else req0 = 1'b0;
    @(negedge clk);
    chk({nm, ".idle.ack"},    {ack1, ack0}, 0);
    chk({nm, ".idle.busy"},   busy,        0);
    chk({nm, ".idle.mem_rw"}, mem_rw,      0);
    if (c.rw) mem_m[c.a] = c.d; else rd_m = mem_m[c.a];
    rr_m = v.eg;
  endtask

  initial begin
    cmd_t nc, q0, q1;
    bit   p0, p1;
    for (int i = 0; i < 8; i++) mem_m[i] = 8'h00;
    rr_m = 1'b1;
    rd_m = 8'h00;
    nc = C(1'b0, 3'd0, 8'h00);

    tbl[0]  = V(1, C(1, 5, 8'h25), 0, nc,             0,         8'h00);
    tbl[1]  = V(0, nc,             1, C(0, 5, 8'h00), 1,         8'h25);
    tbl[2]  = V(1, C(0, 5, 8'h00), 1, C(0, 5, 8'h00), 0,         8'h25);
    tbl[3]  = V(1, C(0, 5, 8'h00), 1, C(0, 5, 8'h00), FIXED ? 1'b0 : 1'b1, 8'h25);
    tbl[4]  = V(1, C(0, 5, 8'h00), 1, C(0, 5, 8'h00), 0,         8'h25);
    tbl[5]  = V(1, C(0, 5, 8'h00), 1, C(0, 5, 8'h00), FIXED ? 1'b0 : 1'b1, 8'h25);
    tbl[6]  = V(1, C(1, 0, 8'h07), 1, C(1, 0, 8'h76), 0,         8'h25);
    tbl[7]  = V(0, nc,             1, C(1, 0, 8'h76), 1,         8'h25);
    tbl[8]  = V(1, C(0, 0, 8'h00), 0, nc,             0,         8'h76);
    tbl[9]  = V(0, nc,             1, C(1, 7, 8'hFF), 1,         8'h76);
    tbl[10] = V(1, C(1, 0, 8'h00), 0, nc,             0,         8'h76);
    tbl[11] = V(0, nc,             1, C(0, 7, 8'h00), 1,         8'hFF);
    tbl[12] = V(1, C(0, 0, 8'h00), 0, nc,             0,         8'h00);
    tbl[13] = V(1, C(1, 0, 8'hFF), 0, nc,             0,         8'h00);
    tbl[14] = V(0, nc,             1, C(1, 7, 8'h00), 1,         8'h00);
    tbl[15] = V(1, C(0, 7, 8'h00), 0, nc,             0,         8'h00);
    tbl[16] = V(0, nc,             1, C(0, 0, 8'h00), 1,         8'hFF);
    tbl[17] = V(1, C(1, 2, 8'h3C), 0, nc,             0,         8'hFF);
    tbl[18] = V(1, C(0, 2, 8'h00), 1, C(0, 7, 8'h00), 0,         8'h3C);
    tbl[19] = V(0, nc,             1, C(0, 7, 8'h00), 1,         8'h00);

    // Reset values while clear is held low.
    #3;
    chk("rst.ack",     {ack1, ack0}, 0);
    chk("rst.mem_rw",  mem_rw,  0);
    chk("rst.mem_add", mem_add, 0);
    chk("rst.mem_din", mem_din, 0);
    chk("rst.rdata",   rdata,   0);
    chk("rst.busy",    busy,    0);
    chk("rst.gnt_id",  gnt_id,  0);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 18; i++) txn(tbl[i], $sformatf("vec%0d", i));

    // Abort: clear drops during the ACCESS cycle of a write to addr 2.
    req0 = 1'b1; rw0 = 1'b1; addr0 = 3'd2; wdata0 = 8'h66; req1 = 1'b0;
    @(negedge clk);
    chk("abort.acc.mem_rw", mem_rw, 1);
    chk("abort.acc.rdata",  rdata,  8'hFF);
    #2 clear = 1'b0; req0 = 1'b0;
    #1;
    chk("abort.async.ack",    {ack1, ack0}, 0);
    chk("abort.async.mem_rw", mem_rw, 0);
    chk("abort.async.busy",   busy,   0);
    chk("abort.async.rdata",  rdata,  0);
    @(negedge clk);
    chk("abort.held.ack",    {ack1, ack0}, 0);
    chk("abort.held.mem_rw", mem_rw, 0);
    clear = 1'b1;
    rr_m = 1'b1;
    rd_m = 8'h00;
    @(negedge clk);
    chk("abort.idle.ack",  {ack1, ack0}, 0);
    chk("abort.idle.busy", busy, 0);

    for (int i = 18; i < 20; i++) txn(tbl[i], $sformatf("vec%0d", i));

    // Random traffic; a losing port keeps requesting and may change its
    // command before it is granted.
    p0 = 1'b0; p1 = 1'b0; q0 = nc; q1 = nc;
    for (int i = 0; i < 80; i++) begin
      vec_t v;
      cmd_t c;
      if (!p0) begin
        if ($urandom_range(1) == 1) begin p0 = 1'b1; q0 = rnd_cmd(); end
      end else if ($urandom_range(3) == 0) q0 = rnd_cmd();
      if (!p1) begin
        if ($urandom_range(1) == 1) begin p1 = 1'b1; q1 = rnd_cmd(); end
      end else if ($urandom_range(3) == 0) q1 = rnd_cmd();
      if (!p0 && !p1) begin p0 = 1'b1; q0 = rnd_cmd(); end
      v.r0 = p0; v.c0 = q0; v.r1 = p1; v.c1 = q1;
      v.eg = pick(p0, p1);
      c = v.eg ? q1 : q0;
      v.erd = c.rw ? rd_m : mem_m[c.a];
      txn(v, $sformatf("rnd%0d", i));
      if (v.eg) p1 = 1'b0; else p0 = 1'b0;
    end
    req0 = 1'b0; req1 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
